// File: rtl/wbs_arbiter.sv
// wbs_arbiter: Wishbone address decoder routing one master to windowed slaves with a bus-timeout watchdog
module wbs_arbiter #(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h3000, 32'h2000, 32'h1000, 32'h0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_HIGH = {32'h3FFF, 32'h2FFF, 32'h1FFF, 32'h0FFF},
  parameter int TIMEOUT = 1024,
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbm_cyc_i,
  input  logic                     wbm_stb_i,
  input  logic                     wbm_we_i,
  input  logic [1:0]               wbm_sel_i,
  input  logic [31:0]              wbm_adr_i,
  input  logic [15:0]              wbm_dat_i,
  output logic [15:0]              wbm_dat_o,
  output logic                     wbm_ack_o,
  output logic                     wbm_err_o,
  output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]    wbs_stb_o,
  output logic                     wbs_we_o,
  output logic [1:0]               wbs_sel_o,
  output logic [31:0]              wbs_adr_o,
  output logic [15:0]              wbs_dat_o,
  input  logic [NUM_SLAVES*16-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]    wbs_err_i,
  output logic [IW-1:0]            wbs_id_o,
  output logic                     timeout_o
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [NUM_SLAVES-1:0] stb_q, stb_d;
  logic we_q, we_d, ack_q, ack_d, err_q, err_d, to_q, to_d;
  logic [1:0] sel_q, sel_d;
  logic [31:0] adr_q, adr_d, hit_base;
  logic [15:0] dat_q, dat_d, rdat_q, rdat_d;
  logic [IW-1:0] id_q, id_d, hit_idx;
  logic [TW-1:0] timer_q, timer_d;
  logic hit;
  assign wbs_cyc_o = stb_q;
  assign wbs_stb_o = stb_q;
  assign wbs_we_o  = we_q;
  assign wbs_sel_o = sel_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = dat_q;
  assign wbs_id_o  = id_q;
  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign timeout_o = to_q;
  // window decode; scanning downwards lets the lowest matching index win
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    hit_base = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--)
      if (wbm_adr_i >= SLAVE_BASE[32*k +: 32] && wbm_adr_i <= SLAVE_HIGH[32*k +: 32]) begin
        hit = 1'b1;
        hit_idx = k[IW-1:0];
        hit_base = SLAVE_BASE[32*k +: 32];
      end
  end
  // transfer sequencing: decode in IDLE, watch the selected slave in WAIT, one response cycle in RESP
  always_comb begin
    state_d = state_q;
    stb_d = stb_q;
    we_d = we_q;
    sel_d = sel_q;
    adr_d = adr_q;
    dat_d = dat_q;
    id_d = id_q;
    timer_d = timer_q;
    rdat_d = rdat_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    to_d = 1'b0;
    case (state_q)
      IDLE: if (wbm_cyc_i && wbm_stb_i) begin
        if (hit) begin
          stb_d = '0;
          stb_d[hit_idx] = 1'b1;
          we_d = wbm_we_i;
          sel_d = wbm_sel_i;
          adr_d = wbm_adr_i - hit_base;
          dat_d = wbm_dat_i;
          id_d = hit_idx;
          timer_d = '0;
          state_d = WAIT;
        end else begin
          err_d = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        stb_d = '0;
        state_d = RESP;
        if (!wbm_cyc_i) state_d = IDLE;
        else if (wbs_err_i[id_q]) err_d = 1'b1;
        else if (wbs_ack_i[id_q]) begin
          ack_d = 1'b1;
          rdat_d = we_q ? rdat_q : wbs_dat_i[{id_q, 4'd0} +: 16];
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          to_d = 1'b1;
        end else begin
          stb_d = stb_q;
          state_d = WAIT;
          timer_d = &timer_q ? timer_q : timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      stb_q <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      id_q <= '0;
      timer_q <= '0;
      rdat_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q <= stb_d;
      we_q <= we_d;
      sel_q <= sel_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      id_q <= id_d;
      timer_q <= timer_d;
      rdat_q <= rdat_d;
      ack_q <= ack_d;
      err_q <= err_d;
      to_q <= to_d;
    end
  end
endmodule

// File: tb/tb_wbs_arbiter.sv
// tb_wbs_arbiter: randomized self-checking bench for wbs_arbiter against a transaction-level model
module tb_wbs_arbiter;
  localparam int TO = 16;
  logic wb_clk_i = 0, wb_rst_i = 0;
  logic wbm_cyc_i = 0, wbm_stb_i = 0, wbm_we_i = 0;
  logic [1:0] wbm_sel_i = 0;
  logic [31:0] wbm_adr_i = 0;
  logic [15:0] wbm_dat_i = 0, wbm_dat_o;
  logic wbm_ack_o, wbm_err_o, wbs_we_o, timeout_o;
  logic [3:0] wbs_cyc_o, wbs_stb_o;
  logic [1:0] wbs_sel_o, wbs_id_o;
  logic [31:0] wbs_adr_o;
  logic [15:0] wbs_dat_o;
  logic [63:0] wbs_dat_i = 0;
  logic [3:0] wbs_ack_i = 0, wbs_err_i = 0;
  int checks = 0, failures = 0;
  logic [15:0] exp_rd = 0;
  int exp_id = 0;
  logic [31:0] base [4] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
  logic [31:0] high [4] = '{32'h0FFF, 32'h1FFF, 32'h2FFF, 32'h3FFF};

  wbs_arbiter #(.TIMEOUT(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_sel_i(wbm_sel_i), .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_id_o(wbs_id_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) begin
    checks++;
    if ((wbm_ack_o && wbm_err_o) || !$onehot0(wbs_stb_o)) begin
      failures++;
      $display("FAIL invariant ack=%b err=%b stb=%b (need not both, onehot0)", wbm_ack_o, wbm_err_o, wbs_stb_o);
    end
  end

  function automatic int decode(logic [31:0] a);
    for (int k = 0; k < 4; k++) if (a >= base[k] && a <= high[k]) return k;
    return -1;
  endfunction

  // kind: 0 ack, 1 err, 2 ack+err, 3 never answers, 4 master drops cyc
  task automatic xfer(input logic [31:0] adr, input logic we, input int lat, input int kind, input bit hold);
    int k, last;
    logic [3:0] oh;
    logic [15:0] wd, rd;
    logic [1:0] sel;
    k = decode(adr);
    wd = 16'($urandom);
    rd = 16'($urandom);
    sel = 2'($urandom);
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = we; wbm_sel_i = sel; wbm_adr_i = adr; wbm_dat_i = wd;
    @(posedge wb_clk_i); #1;
    if (k < 0) begin
      checks++;
      if (wbs_stb_o !== 4'b0 || wbm_err_o !== 1'b1 || wbm_ack_o !== 1'b0)
        begin failures++; $display("FAIL unmapped adr=%h stb=%b err=%b ack=%b need 0000/1/0", adr, wbs_stb_o, wbm_err_o, wbm_ack_o); end
    end else begin
      oh = 4'b1 << k;
      exp_id = k;
      checks++;
      if (wbs_cyc_o !== oh || wbs_stb_o !== oh)
        begin failures++; $display("FAIL strobe adr=%h cyc=%b stb=%b need %b", adr, wbs_cyc_o, wbs_stb_o, oh); end
      checks++;
      if (wbs_adr_o !== adr - base[k] || wbs_we_o !== we || wbs_sel_o !== sel || wbs_dat_o !== wd || wbs_id_o !== k[1:0])
        begin failures++; $display("FAIL latch adr=%h got %h/%b/%b/%h/%0d need %h/%b/%b/%h/%0d", adr, wbs_adr_o, wbs_we_o, wbs_sel_o, wbs_dat_o, wbs_id_o, adr - base[k], we, sel, wd, k); end
      last = kind == 3 ? TO - 1 : lat;
      for (int c = 0; c <= last; c++) begin
        wbs_ack_i = 4'($urandom) & ~oh;
        wbs_err_i = 4'($urandom) & ~oh;
        wbs_dat_i = {$urandom, $urandom};
        if (c == lat && kind != 3) begin
          if (kind == 0 || kind == 2) begin wbs_ack_i[k] = 1; wbs_dat_i[16*k +: 16] = rd; end
          if (kind == 1 || kind == 2) wbs_err_i[k] = 1;
          if (kind == 4) begin wbm_cyc_i = 0; wbm_stb_i = 0; end
        end
        @(posedge wb_clk_i); #1;
        wbs_ack_i = 0; wbs_err_i = 0;
        if (c < last) begin
          checks++;
          if (wbs_stb_o !== oh || wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0)
            begin failures++; $display("FAIL wait c=%0d stb=%b ack=%b err=%b need %b/0/0", c, wbs_stb_o, wbm_ack_o, wbm_err_o, oh); end
        end
      end
      if (kind == 0 && !we) exp_rd = rd;
      checks++;
      if (wbs_stb_o !== 4'b0 || wbs_cyc_o !== 4'b0 || wbm_ack_o !== (kind == 0) || wbm_err_o !== (kind inside {1, 2, 3}) ||
          timeout_o !== (kind == 3) || wbm_dat_o !== exp_rd)
        begin failures++; $display("FAIL resp kind=%0d stb=%b ack=%b err=%b to=%b dat=%h need stb=0 ack=%b err=%b to=%b dat=%h",
          kind, wbs_stb_o, wbm_ack_o, wbm_err_o, timeout_o, wbm_dat_o, kind == 0, kind inside {1, 2, 3}, kind == 3, exp_rd); end
    end
    if (!hold) begin wbm_cyc_i = 0; wbm_stb_i = 0; end
    @(posedge wb_clk_i); #1;
    checks++;
    if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0 || timeout_o !== 1'b0 || wbs_stb_o !== 4'b0 || wbm_dat_o !== exp_rd || wbs_id_o !== exp_id[1:0])
      begin failures++; $display("FAIL idle ack=%b err=%b to=%b stb=%b dat=%h id=%0d need 0/0/0/0000/%h/%0d",
        wbm_ack_o, wbm_err_o, timeout_o, wbs_stb_o, wbm_dat_o, wbs_id_o, exp_rd, exp_id); end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({wbm_dat_o, wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o, wbs_id_o, timeout_o} !== '0)
      begin failures++; $display("FAIL %s outputs not zero: dat=%h ack=%b err=%b cyc=%b stb=%b adr=%h id=%0d to=%b",
        name, wbm_dat_o, wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o, wbs_adr_o, wbs_id_o, timeout_o); end
  endtask

  task automatic test_reset;
    wb_rst_i = 1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    check_zero("reset");
    wb_rst_i = 0;
    exp_rd = 0; exp_id = 0;
  endtask

  task automatic test_write_ack;
    xfer(32'h1004, 1, 3, 0, 0);
  endtask

  task automatic test_read_ignore_other;
    xfer(32'h3010, 0, 2, 0, 0);
    xfer(32'h0010, 0, 0, 0, 0);
  endtask

  task automatic test_unmapped;
    xfer(32'h8000, 0, 0, 0, 0);
    xfer(32'hFFFF_FFFF, 1, 0, 0, 0);
  endtask

  task automatic test_timeout;
    xfer(32'h2100, 1, 0, 3, 0);
    xfer(32'h0020, 0, 1, 0, 0);
  endtask

  task automatic test_ack_err;
    xfer(32'h0040, 0, 1, 2, 0);
    xfer(32'h1040, 0, 2, 1, 0);
  endtask

  task automatic test_abort;
    xfer(32'h2040, 0, 2, 4, 0);
  endtask

  task automatic test_reset_wait;
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 0; wbm_adr_i = 32'h1008;
    @(posedge wb_clk_i); #1;
    checks++;
    if (wbs_stb_o !== 4'b0010)
      begin failures++; $display("FAIL rst_wait strobe stb=%b need 0010", wbs_stb_o); end
    wb_rst_i = 1;
    @(posedge wb_clk_i); #1;
    check_zero("reset_in_wait");
    wb_rst_i = 0; wbm_cyc_i = 0; wbm_stb_i = 0;
    exp_rd = 0; exp_id = 0;
    xfer(32'h0000, 0, 0, 0, 0);
  endtask

  task automatic test_boundaries;
    xfer(32'h0FFF, 0, 0, 0, 0);
    xfer(32'h1000, 0, 0, 0, 0);
    xfer(32'h3FFF, 0, 1, 0, 0);
    xfer(32'h4000, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    xfer(32'h2222, 0, 0, 0, 1);
    xfer(32'h2222, 0, 1, 0, 1);
    xfer(32'h9000, 0, 0, 0, 1);
    xfer(32'h3333, 1, 0, 0, 0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    int kinds [7] = '{0, 0, 0, 1, 2, 3, 4};
    for (int i = 0; i < 60; i++) begin
      a = ($urandom % 5 == 0) ? 32'h4000 + $urandom : {18'b0, 2'($urandom), 12'($urandom)};
      xfer(a, 1'($urandom), $urandom_range(0, 4), kinds[$urandom % 7], 1'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_write_ack;
    test_read_ignore_other;
    test_unmapped;
    test_timeout;
    test_ack_err;
    test_abort;
    test_reset_wait;
    test_boundaries;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wbs_arbiter.md
Name: wbs_arbiter

Overview:
Wishbone slave-side address decoder and arbiter. It connects one 16-bit Wishbone master, normally the output of wbm_arbiter, to NUM_SLAVES slaves using per-slave address windows. It sequences each transfer with registered strobes and a bus-timeout watchdog. Unmapped accesses, slave errors and hung slaves are all terminated with err so the shared bus never locks.

Parameters:
NUM_SLAVES, 4, number of slave ports.
SLAVE_BASE, {32'h3000,32'h2000,32'h1000,32'h0000}, packed NUM_SLAVES*32 window base addresses; slave k uses bits [32k+31:32k].
SLAVE_HIGH, {32'h3FFF,32'h2FFF,32'h1FFF,32'h0FFF}, packed inclusive window top addresses.
TIMEOUT, 1024, cycles in WAIT before the transfer is aborted with err; minimum 2.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wbm_cyc_i  in  1  master cycle
wbm_stb_i  in  1  master strobe
wbm_we_i  in  1  master write enable
wbm_sel_i  in  2  master byte selects
wbm_adr_i  in  32  master address
wbm_dat_i  in  16  master write data
wbm_dat_o  out  16  read data to master
wbm_ack_o  out  1  ack to master
wbm_err_o  out  1  err to master
wbs_cyc_o  out  NUM_SLAVES  per-slave cycle
wbs_stb_o  out  NUM_SLAVES  per-slave strobe
wbs_we_o  out  1  shared write enable
wbs_sel_o  out  2  shared byte selects
wbs_adr_o  out  32  shared address, window-relative (wbm_adr_i - SLAVE_BASE[k])
wbs_dat_o  out  16  shared write data
wbs_dat_i  in  NUM_SLAVES*16  per-slave read data
wbs_ack_i  in  NUM_SLAVES  per-slave ack
wbs_err_i  in  NUM_SLAVES  per-slave err
wbs_id_o  out  clog2(NUM_SLAVES)  index of the last selected slave
timeout_o  out  1  one-cycle pulse when a timeout abort occurs

Behaviour:
- All outputs are registered. While wb_rst_i is high, every output is 0 and the state is IDLE, taking effect at the next edge. A reset during WAIT drops all slave strobes on that edge and produces no ack or err.
- States: IDLE, WAIT, RESP.
- IDLE, with wbm_cyc_i & wbm_stb_i sampled at edge t:
  - Decode: slave k matches when SLAVE_BASE[k] <= adr <= SLAVE_HIGH[k]. If windows overlap, the lowest index wins.
  - On a match, at t+1: wbs_cyc_o[k]=wbs_stb_o[k]=1; we/sel/dat and relative adr are latched; wbs_id_o=k; timer=0; go to WAIT.
  - On no match, at t+1: wbm_err_o=1 for one cycle, no slave is strobed, go to RESP.
- WAIT checks only the selected slave k; acks and errs from other slaves are ignored. Conditions, in priority order:
  1. wbm_cyc_i==0: abort. Strobes drop at the next edge, no ack or err, go to IDLE.
  2. wbs_err_i[k]: next edge drops strobes, wbm_err_o=1, go to RESP.
  3. wbs_ack_i[k]: next edge drops strobes, wbm_ack_o=1, wbm_dat_o=wbs_dat_i[16k+15:16k], go to RESP.
  4. timer==TIMEOUT-1: next edge drops strobes, wbm_err_o=1, timeout_o=1, go to RESP.
  5. Otherwise timer increments; it saturates and does not wrap.
- When ack and err arrive in the same cycle, err wins. Latency from request to slave strobe is 1 cycle; from slave ack to master ack is 1 cycle.
- RESP lasts one cycle. wbm_ack_o/wbm_err_o is high during it, master inputs are ignored so a still-high stb is not reissued, then go to IDLE. A back-to-back request can therefore be sampled 2 cycles after the response edge at the earliest.
- wbm_ack_o and wbm_err_o are never both high. At most one wbs_stb_o bit is high at any time.
- wbm_dat_o holds its value outside ack cycles. Writes do not alter it.
- Address subtraction is 32-bit modular.

Test Plan:
All scenarios use the default parameters and TIMEOUT=16.
1. Write adr 0x1004, dat 0xBEEF; slave1 acks 3 cycles after its strobe -> wbs_stb_o=4'b0010, wbs_adr_o=0x0004, wbs_dat_o=0xBEEF; one-cycle wbm_ack_o on the edge after the ack; wbs_id_o=1.
2. Read adr 0x3010; slave3 returns 0x1234 with ack -> wbm_dat_o=0x1234 with a single wbm_ack_o pulse; slave0 asserting ack simultaneously has no effect.
3. Read adr 0x8000 (unmapped) -> no wbs_stb_o asserted; wbm_err_o pulses exactly one cycle after the request.
4. Write to slave2, which never acks -> wbs_stb_o[2] is high for exactly 16 cycles; then wbm_err_o=1 and timeout_o=1 for one cycle; the next request to slave0 completes normally.
5. Slave0 asserts wbs_ack_i and wbs_err_i in the same cycle -> wbm_err_o=1, wbm_ack_o=0. Separately, the master drops cyc during WAIT -> strobes clear and no response is produced.
6. Assert wb_rst_i during WAIT on slave1 -> all outputs are 0 on the next edge. After release, a read of 0x0000 works with 1-cycle strobe latency.
